// File: rtl/npc_redirect_unit.sv
// Fetch PC register and next-PC selection with MIPS delay-slot redirects (branch, j/jal, jr/jalr).
// Optional jr target alignment flag enabled by defining NPC_ALIGN_CHECK_EN.
module npc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        branch,
    input  logic [15:0] br_imm,
    input  logic        jump,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        if_ready,
    output logic [31:0] pc,
    output logic        if_req,
    output logic        redirect_busy,
    output logic        pc_misalign
);

    typedef enum logic {
        RUN,
        PEND
    } state_t;

    state_t      state;
    logic [31:0] pend_target;
    logic [31:0] id_npc;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        redir;
    logic        advance;

    assign id_npc  = id_pc + 32'd4;
    assign seq_pc  = pc + 32'(PC_STEP);
    assign redir   = id_valid & ~stall & (branch | jump | jr);
    assign advance = if_req & if_ready & ~stall;

    // jr has priority over jump, jump over branch.
    always_comb begin
        target = id_npc + {{14{br_imm[15]}}, br_imm, 2'b00};
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = {id_npc[31:28], j_index, 2'b00};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain updates within a single edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            pc            <= RESET_PC;
            pend_target   <= 32'd0;
            if_req        <= 1'b0;
            redirect_busy <= 1'b0;
        end else begin
            if_req <= 1'b1;
            case (state)
                RUN: begin
                    if (redir) begin
                        if (advance) begin
                            // Delay slot is the word at pc, fetched this cycle.
                            pc <= target;
                        end else begin
                            pend_target   <= target;
                            redirect_busy <= 1'b1;
                            state         <= PEND;
                        end
                    end else if (advance) begin
                        pc <= seq_pc;
                    end
                end
                PEND: begin
                    if (advance) begin
                        pc            <= pend_target;
                        redirect_busy <= 1'b0;
                        state         <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef NPC_ALIGN_CHECK_EN
    // One-cycle flag on capture of a misaligned jr target; the target itself is loaded as-is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_misalign <= 1'b0;
        end else begin
            pc_misalign <= (state == RUN) & redir & jr & (jr_target[1:0] != 2'b00);
        end
    end
`else
    assign pc_misalign = 1'b0;
`endif

endmodule
